// File: rtl/img_stream_rx.sv
// Pixel stream receiver: tags each accepted beat with x/y and checks frame framing/length.
// Reports per-frame status and a mod-2^32 checksum when each frame terminates.
module img_stream_rx #(
   parameter int H_ACT = 1280,
   parameter int V_ACT = 720,
   parameter int DW    = 16,
   parameter int XW    = 11,
   parameter int YW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic          din_vld,
   input  logic          din_sop,
   input  logic          din_eop,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   output logic [XW-1:0] pix_x,
   output logic [YW-1:0] pix_y,
   output logic          frame_done,
   output logic          frame_ok,
   output logic          err_len,
   output logic          err_eop,
   output logic          err_sop,
   output logic [31:0]   checksum,
   output logic [15:0]   frame_cnt
);

   typedef enum logic {IDLE, RECV} state_t;

   localparam logic [XW-1:0] X_LAST = XW'(H_ACT - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACT - 1);

   state_t          state, state_d;
   logic [XW-1:0]   x_cnt, x_d, cur_x;
   logic [YW-1:0]   y_cnt, y_d, cur_y;
   logic [31:0]     sum_q, sum_d, cur_sum;
   logic            accept, is_last, old_term, new_term;
   logic [3:0]      new_stat;
   logic            emit_vld;
   logic [3:0]      emit_stat;
   logic [31:0]     emit_sum;
   logic            pend_vld, pend_vld_d;
   logic [3:0]      pend_stat, pend_stat_d;
   logic [31:0]     pend_sum, pend_sum_d;

   // Status nibbles are {ok, len, eop, sop}. x_cnt/y_cnt hold the position the next
   // non-sop beat will occupy. A second termination in the same cycle (sop+eop in RECV)
   // is parked in the pend_* slot and reported on the following cycle.
   always_comb begin
      state_d     = state;
      accept      = 1'b0;
      cur_x       = x_cnt;
      cur_y       = y_cnt;
      cur_sum     = sum_q + 32'(din);
      x_d         = x_cnt;
      y_d         = y_cnt;
      sum_d       = sum_q;
      new_term    = 1'b0;
      new_stat    = 4'b0000;
      emit_vld    = 1'b0;
      emit_stat   = 4'b0000;
      emit_sum    = 32'd0;
      pend_vld_d  = 1'b0;
      pend_stat_d = pend_stat;
      pend_sum_d  = pend_sum;

      accept   = din_vld && (state == RECV || din_sop);
      old_term = din_vld && din_sop && (state == RECV);
      if (din_sop) begin
         cur_x   = '0;
         cur_y   = '0;
         cur_sum = 32'(din);
      end
      is_last = (cur_x == X_LAST) && (cur_y == Y_LAST);

      if (accept) begin
         new_term = din_eop || is_last;
         new_stat = {din_eop && is_last, din_eop && !is_last, !din_eop && is_last, 1'b0};
         state_d  = new_term ? IDLE : RECV;
         sum_d    = cur_sum;
         if (cur_x == X_LAST) begin
            x_d = '0;
            y_d = cur_y + YW'(1);
         end else begin
            x_d = cur_x + XW'(1);
            y_d = cur_y;
         end
      end

      if (pend_vld) begin
         emit_vld  = 1'b1;
         emit_stat = pend_stat;
         emit_sum  = pend_sum;
         if (new_term) begin
            pend_vld_d  = 1'b1;
            pend_stat_d = new_stat;
            pend_sum_d  = cur_sum;
         end
      end else if (old_term) begin
         emit_vld  = 1'b1;
         emit_stat = 4'b0001;
         emit_sum  = sum_q;
         if (new_term) begin
            pend_vld_d  = 1'b1;
            pend_stat_d = new_stat;
            pend_sum_d  = cur_sum;
         end
      end else if (new_term) begin
         emit_vld  = 1'b1;
         emit_stat = new_stat;
         emit_sum  = cur_sum;
      end
   end

   // Registered outputs; data/coordinates and frame status hold between updates.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         x_cnt      <= '0;
         y_cnt      <= '0;
         sum_q      <= 32'd0;
         pend_vld   <= 1'b0;
         pend_stat  <= 4'b0000;
         pend_sum   <= 32'd0;
         dout       <= '0;
         dout_vld   <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         err_len    <= 1'b0;
         err_eop    <= 1'b0;
         err_sop    <= 1'b0;
         checksum   <= 32'd0;
         frame_cnt  <= 16'd0;
      end else begin
         state      <= state_d;
         x_cnt      <= x_d;
         y_cnt      <= y_d;
         sum_q      <= sum_d;
         pend_vld   <= pend_vld_d;
         pend_stat  <= pend_stat_d;
         pend_sum   <= pend_sum_d;
         dout_vld   <= accept;
         frame_done <= emit_vld;
         if (accept) begin
            dout  <= din;
            pix_x <= cur_x;
            pix_y <= cur_y;
         end
         if (emit_vld) begin
            {frame_ok, err_len, err_eop, err_sop} <= emit_stat;
            checksum <= emit_sum;
            if (emit_stat[3])
               frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_img_stream_rx.sv
// Self-checking bench for img_stream_rx on an 8x4 frame: constant vector table, directed
// corner sequences and randomized traffic against a frame-level reference model.
module tb_img_stream_rx;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int DW = 16;
   localparam int XW = 3;
   localparam int YW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] din;
   logic          din_vld, din_sop, din_eop;
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic          frame_done, frame_ok, err_len, err_eop, err_sop;
   logic [31:0]   checksum;
   logic [15:0]   frame_cnt;

   img_stream_rx #(.H_ACT(H), .V_ACT(V), .DW(DW), .XW(XW), .YW(YW)) dut (
      .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_sop(din_sop),
      .din_eop(din_eop), .dout(dout), .dout_vld(dout_vld), .pix_x(pix_x), .pix_y(pix_y),
      .frame_done(frame_done), .frame_ok(frame_ok), .err_len(err_len), .err_eop(err_eop),
      .err_sop(err_sop), .checksum(checksum), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: a frame is the list of its accepted pixels; terminations queue up
   // as events and the outputs report at most one event per cycle.
   typedef struct {
      bit          ok;
      bit          len;
      bit          eopE;
      bit          sopE;
      logic [31:0] sum;
   } ev_t;

   ev_t           evq[$];
   logic [DW-1:0] fq[$];
   bit            inFrame;
   logic [DW-1:0] hDout;
   logic [XW-1:0] hX;
   logic [YW-1:0] hY;
   bit            hOk, hLen, hEop, hSop;
   logic [31:0]   hSum;
   logic [15:0]   hCnt;

   typedef struct {
      bit          v, s, e;
      logic [15:0] d;
      bit          eV;
      int          eX, eY;
      bit          eD, eOk;
      logic [31:0] eSum;
   } vec_t;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] frameSum();
      logic [31:0] s;
      s = 32'd0;
      foreach (fq[i]) s = s + 32'(fq[i]);
      return s;
   endfunction

   task automatic modelReset();
      evq.delete();
      fq.delete();
      inFrame = 1'b0;
      hDout = '0; hX = '0; hY = '0;
      hOk = 1'b0; hLen = 1'b0; hEop = 1'b0; hSop = 1'b0;
      hSum = 32'd0; hCnt = 16'd0;
   endtask

   task automatic applyStimulus(input bit v, input bit s, input bit e, input logic [DW-1:0] d);
      bit  expVld, expDone;
      int  idx;
      ev_t ev;
      @(negedge clk);
      din_vld = v; din_sop = s; din_eop = e; din = d;
      @(posedge clk);
      #1;
      expVld = 1'b0;
      if (v) begin
         if (s) begin
            if (inFrame) begin
               ev.ok = 1'b0; ev.len = 1'b0; ev.eopE = 1'b0; ev.sopE = 1'b1;
               ev.sum = frameSum();
               evq.push_back(ev);
            end
            fq.delete();
            inFrame = 1'b1;
         end
         if (inFrame) begin
            fq.push_back(d);
            expVld = 1'b1;
            idx    = fq.size() - 1;
            hDout  = d;
            hX     = XW'(idx % H);
            hY     = YW'(idx / H);
            if (e || idx == H*V-1) begin
               ev.ok   = e && (idx == H*V-1);
               ev.len  = e && (idx != H*V-1);
               ev.eopE = !e;
               ev.sopE = 1'b0;
               ev.sum  = frameSum();
               evq.push_back(ev);
               inFrame = 1'b0;
            end
         end
      end
      expDone = evq.size() > 0;
      if (expDone) begin
         ev   = evq.pop_front();
         hOk  = ev.ok; hLen = ev.len; hEop = ev.eopE; hSop = ev.sopE;
         hSum = ev.sum;
         if (ev.ok) hCnt = hCnt + 16'd1;
      end
      checkOutput("dout_vld",   32'(dout_vld),   32'(expVld));
      checkOutput("dout",       32'(dout),       32'(hDout));
      checkOutput("pix_x",      32'(pix_x),      32'(hX));
      checkOutput("pix_y",      32'(pix_y),      32'(hY));
      checkOutput("frame_done", 32'(frame_done), 32'(expDone));
      checkOutput("frame_ok",   32'(frame_ok),   32'(hOk));
      checkOutput("err_len",    32'(err_len),    32'(hLen));
      checkOutput("err_eop",    32'(err_eop),    32'(hEop));
      checkOutput("err_sop",    32'(err_sop),    32'(hSop));
      checkOutput("checksum",   checksum,        hSum);
      checkOutput("frame_cnt",  32'(frame_cnt),  32'(hCnt));
   endtask

   // A beat presented during reset must be ignored and every output must read zero.
   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0; din_vld = 1'b1; din_sop = 1'b1; din_eop = 1'b0; din = 16'hABCD;
      @(posedge clk);
      #1;
      modelReset();
      checkOutput("rst_dout_vld",   32'(dout_vld),   32'd0);
      checkOutput("rst_dout",       32'(dout),       32'd0);
      checkOutput("rst_pix_x",      32'(pix_x),      32'd0);
      checkOutput("rst_pix_y",      32'(pix_y),      32'd0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
      checkOutput("rst_frame_ok",   32'(frame_ok),   32'd0);
      checkOutput("rst_errs",       32'({err_len, err_eop, err_sop}), 32'd0);
      checkOutput("rst_checksum",   checksum,        32'd0);
      checkOutput("rst_frame_cnt",  32'(frame_cnt),  32'd0);
      @(negedge clk);
      rst_n = 1'b1; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
   endtask

   initial begin
      vec_t tbl[11];
      int   beat, cyc;
      bit   v, s, e;
      int   nextIdx;

      rst_n = 1'b0; din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
      modelReset();
      doReset();

      // Vector table: dropped beat, ignored invalid sop/eop, short frame, sop+eop in IDLE,
      // and sop+eop in RECV giving two consecutive frame_done pulses.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'd5,  1'b0, 0, 0, 1'b0, 1'b0, 32'd0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'd10, 1'b1, 0, 0, 1'b0, 1'b0, 32'd0};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'd99, 1'b0, 0, 0, 1'b0, 1'b0, 32'd0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'd11, 1'b1, 1, 0, 1'b0, 1'b0, 32'd0};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'd12, 1'b1, 2, 0, 1'b1, 1'b0, 32'd33};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'd13, 1'b0, 0, 0, 1'b0, 1'b0, 32'd0};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 16'd20, 1'b1, 0, 0, 1'b1, 1'b0, 32'd20};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'd30, 1'b1, 0, 0, 1'b0, 1'b0, 32'd0};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'd40, 1'b1, 0, 0, 1'b1, 1'b0, 32'd30};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 0, 0, 1'b1, 1'b0, 32'd40};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 16'd0,  1'b0, 0, 0, 1'b0, 1'b0, 32'd0};
      for (int i = 0; i < 11; i++) begin
         applyStimulus(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
         checkOutput($sformatf("tbl%0d_vld", i), 32'(dout_vld), 32'(tbl[i].eV));
         if (tbl[i].eV) begin
            checkOutput($sformatf("tbl%0d_x", i), 32'(pix_x), 32'(tbl[i].eX));
            checkOutput($sformatf("tbl%0d_y", i), 32'(pix_y), 32'(tbl[i].eY));
         end
         checkOutput($sformatf("tbl%0d_done", i), 32'(frame_done), 32'(tbl[i].eD));
         if (tbl[i].eD) begin
            checkOutput($sformatf("tbl%0d_ok", i),  32'(frame_ok), 32'(tbl[i].eOk));
            checkOutput($sformatf("tbl%0d_sum", i), checksum,      tbl[i].eSum);
         end
      end
      checkOutput("tbl9_len", 32'(err_len), 32'd1);

      doReset();
      for (int i = 0; i < 32; i++) applyStimulus(1'b1, i == 0, i == 31, DW'(i));
      checkOutput("t1_done", 32'(frame_done), 32'd1);
      checkOutput("t1_ok",   32'(frame_ok),   32'd1);
      checkOutput("t1_sum",  checksum,        32'd496);
      checkOutput("t1_cnt",  32'(frame_cnt),  32'd1);
      checkOutput("t1_xy",   32'({pix_x, pix_y}), 32'({3'd7, 2'd3}));

      beat = 0; cyc = 0;
      while (beat < 32) begin
         if (cyc % 3 == 2) applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234);
         else begin
            applyStimulus(1'b1, beat == 0, beat == 31, 16'hFFFF);
            beat++;
         end
         cyc++;
      end
      checkOutput("t2_sum", checksum,       32'h001F_FFE0);
      checkOutput("t2_ok",  32'(frame_ok),  32'd1);
      checkOutput("t2_cnt", 32'(frame_cnt), 32'd2);

      for (int i = 0; i <= 20; i++) applyStimulus(1'b1, i == 0, i == 20, DW'(i));
      checkOutput("t3_len", 32'(err_len),   32'd1);
      checkOutput("t3_ok",  32'(frame_ok),  32'd0);
      checkOutput("t3_cnt", 32'(frame_cnt), 32'd2);
      checkOutput("t3_xy",  32'({pix_x, pix_y}), 32'({3'd4, 2'd2}));
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, DW'($urandom));
         checkOutput("t3_drop", 32'(dout_vld), 32'd0);
      end

      for (int i = 0; i < 32; i++) applyStimulus(1'b1, i == 0, 1'b0, DW'(i + 100));
      checkOutput("t4_done", 32'(frame_done), 32'd1);
      checkOutput("t4_eop",  32'(err_eop),    32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, DW'(i));
      for (int i = 0; i < 32; i++) applyStimulus(1'b1, i == 0, i == 31, DW'(i * 3));
      checkOutput("t4_ok",  32'(frame_ok),  32'd1);
      checkOutput("t4_cnt", 32'(frame_cnt), 32'd3);

      for (int i = 0; i < 10; i++) applyStimulus(1'b1, i == 0, 1'b0, DW'(i));
      applyStimulus(1'b1, 1'b1, 1'b0, 16'd77);
      checkOutput("t5_done", 32'(frame_done), 32'd1);
      checkOutput("t5_sop",  32'(err_sop),    32'd1);
      checkOutput("t5_sum",  checksum,        32'd45);
      checkOutput("t5_new",  32'({dout, pix_x, pix_y}), 32'({16'd77, 3'd0, 2'd0}));
      for (int i = 1; i < 32; i++) applyStimulus(1'b1, 1'b0, i == 31, DW'(i));
      checkOutput("t5_ok",  32'(frame_ok),  32'd1);
      checkOutput("t5_cnt", 32'(frame_cnt), 32'd4);

      for (int i = 0; i < 15; i++) applyStimulus(1'b1, i == 0, 1'b0, DW'(i));
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 16'd1);
         checkOutput("t6_nodone", 32'(frame_done), 32'd0);
      end
      for (int i = 0; i < 32; i++) applyStimulus(1'b1, i == 0, i == 31, DW'(i + 7));
      checkOutput("t6_ok",  32'(frame_ok),  32'd1);
      checkOutput("t6_cnt", 32'(frame_cnt), 32'd1);

      // Random traffic: mostly good frames with gaps, occasional early eop, missing eop,
      // premature sop and resets.
      for (int n = 0; n < 2500; n++) begin
         if ($urandom % 700 == 0) doReset();
         v = ($urandom % 4) != 0;
         s = inFrame ? ($urandom % 60 == 0) : ($urandom % 3 == 0);
         nextIdx = (s || !inFrame) ? 0 : fq.size();
         e = (nextIdx == H*V-1) ? ($urandom % 8 != 0) : ($urandom % 50 == 0);
         applyStimulus(v, s, e, DW'($urandom));
      end
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
